// File: rtl/compute_cluster_if.sv
// ---------------------------------------------------------------------------
// compute_cluster_if
// Groups every compute_cluster signal except clock and reset.
//   master : the controller side. It drives the IFM/filter write beats, the
//            run control and the readout selects. It observes the done flag
//            and the readout data.
//   slave  : the compute_cluster side, with the opposite directions.
// Signal groups:
//   ifm_*      IFM write beat (map, compacted bytes, valid, beat index, bank)
//              and the IFM bank used for compute.
//   filter_*   filter write beat, target unit and compute bank.
//   run/chunk  run_valid_i, chunk_start_i, rd_sparsemap_num_i, acc_buf_sel_i.
//   readout    out_buf_sel_i, com_unit_out_buf_sel_i, out_buf_dat_o.
//   status     total_chunk_end_o (1 while idle).
// ---------------------------------------------------------------------------
interface compute_cluster_if #(
  parameter int MEM_SIZE         = 128,
  parameter int BUS_SIZE         = 32,
  parameter int PREFIX_SUM_SIZE  = 32,
  parameter int COMPUTE_UNIT_NUM = 4,
  parameter int OUTPUT_BUF_NUM   = 4,
  parameter int OUTPUT_BUF_SIZE  = 32
);
  localparam int WR_CYC = MEM_SIZE / BUS_SIZE;
  localparam int RD_NUM = MEM_SIZE / PREFIX_SUM_SIZE;
  localparam int WC_W   = (WR_CYC > 1) ? $clog2(WR_CYC) : 1;
  localparam int RD_W   = (RD_NUM > 1) ? $clog2(RD_NUM) : 1;
  localparam int OB_W   = (OUTPUT_BUF_NUM > 1) ? $clog2(OUTPUT_BUF_NUM) : 1;
  localparam int CU_W   = (COMPUTE_UNIT_NUM > 1) ? $clog2(COMPUTE_UNIT_NUM) : 1;

  logic [BUS_SIZE-1:0]        ifm_sparsemap_i;
  logic [BUS_SIZE*8-1:0]      ifm_nonzero_data_i;
  logic                       ifm_wr_valid_i;
  logic [WC_W-1:0]            ifm_wr_count_i;
  logic                       ifm_wr_sel_i;
  logic                       ifm_rd_sel_i;

  logic [BUS_SIZE-1:0]        filter_sparsemap_i;
  logic [BUS_SIZE*8-1:0]      filter_nonzero_data_i;
  logic                       filter_wr_valid_i;
  logic [WC_W-1:0]            filter_wr_count_i;
  logic                       filter_wr_sel_i;
  logic                       filter_rd_sel_i;
  logic [OB_W-1:0]            filter_wr_order_sel_i;

  logic                       run_valid_i;
  logic                       chunk_start_i;
  logic [RD_W-1:0]            rd_sparsemap_num_i;
  logic                       total_chunk_end_o;
  logic [OB_W-1:0]            acc_buf_sel_i;

  logic [OB_W-1:0]            out_buf_sel_i;
  logic [CU_W-1:0]            com_unit_out_buf_sel_i;
  logic [OUTPUT_BUF_SIZE-1:0] out_buf_dat_o;

  modport master (
    output ifm_sparsemap_i, ifm_nonzero_data_i, ifm_wr_valid_i, ifm_wr_count_i,
           ifm_wr_sel_i, ifm_rd_sel_i,
           filter_sparsemap_i, filter_nonzero_data_i, filter_wr_valid_i,
           filter_wr_count_i, filter_wr_sel_i, filter_rd_sel_i, filter_wr_order_sel_i,
           run_valid_i, chunk_start_i, rd_sparsemap_num_i, acc_buf_sel_i,
           out_buf_sel_i, com_unit_out_buf_sel_i,
    input  total_chunk_end_o, out_buf_dat_o
  );

  modport slave (
    input  ifm_sparsemap_i, ifm_nonzero_data_i, ifm_wr_valid_i, ifm_wr_count_i,
           ifm_wr_sel_i, ifm_rd_sel_i,
           filter_sparsemap_i, filter_nonzero_data_i, filter_wr_valid_i,
           filter_wr_count_i, filter_wr_sel_i, filter_rd_sel_i, filter_wr_order_sel_i,
           run_valid_i, chunk_start_i, rd_sparsemap_num_i, acc_buf_sel_i,
           out_buf_sel_i, com_unit_out_buf_sel_i,
    output total_chunk_end_o, out_buf_dat_o
  );
endinterface

// File: rtl/compute_cluster.sv
// ---------------------------------------------------------------------------
// compute_cluster
// Sparse dot-product cluster. A double-buffered IFM store is shared by
// COMPUTE_UNIT_NUM units. Each unit owns a double-buffered filter store and
// OUTPUT_BUF_NUM accumulators. Operands are stored as a sparse map plus bytes
// compacted in map order. A run walks sub-chunks of PREFIX_SUM_SIZE map bits.
// In each cycle, every unit consumes its lowest remaining position where both
// the IFM and filter maps are set, and it accumulates the unsigned 8x8 product.
// Ports:
//   clk_i : clock
//   rst_i : synchronous, active-low reset (FSM, sub-chunk index, accumulators)
//   cc    : compute_cluster_if.slave (write beats, run control, readout)
// ---------------------------------------------------------------------------
module compute_cluster #(
  parameter int MEM_SIZE         = 128,
  parameter int BUS_SIZE         = 32,
  parameter int PREFIX_SUM_SIZE  = 32,
  parameter int COMPUTE_UNIT_NUM = 4,
  parameter int OUTPUT_BUF_NUM   = 4,
  parameter int OUTPUT_BUF_SIZE  = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  compute_cluster_if.slave cc
);
  localparam int WR_CYC = MEM_SIZE / BUS_SIZE;
  localparam int RD_NUM = MEM_SIZE / PREFIX_SUM_SIZE;
  localparam int WC_W   = (WR_CYC > 1) ? $clog2(WR_CYC) : 1;
  localparam int RD_W   = (RD_NUM > 1) ? $clog2(RD_NUM) : 1;
  localparam int OB_W   = (OUTPUT_BUF_NUM > 1) ? $clog2(OUTPUT_BUF_NUM) : 1;
  localparam int AD_W   = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam int PS     = PREFIX_SUM_SIZE;
  localparam int CU     = COMPUTE_UNIT_NUM;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  // First map/byte index covered by write beat c.
  function automatic logic [AD_W-1:0] beat_base(input logic [WC_W-1:0] c);
    return AD_W'(int'(c) * BUS_SIZE);
  endfunction

  // Map bits of sub-chunk k.
  function automatic logic [PS-1:0] sub_chunk(input logic [MEM_SIZE-1:0] map,
                                              input logic [RD_W-1:0] k);
    return PS'(map >> (int'(k) * PS));
  endfunction

  // Position of the single set bit of a one-hot vector (0 when empty).
  function automatic int lsb_index(input logic [PS-1:0] v);
    int idx;
    idx = 0;
    for (int i = PS - 1; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

  // Compacted-byte address of map position pos: the number of set map bits below it.
  function automatic logic [AD_W-1:0] rank(input logic [MEM_SIZE-1:0] map, input int pos);
    logic [MEM_SIZE-1:0] below;
    below = (MEM_SIZE'(1) << pos) - MEM_SIZE'(1);
    return AD_W'($countones(map & below));
  endfunction

  // Unsigned 8x8 multiply-accumulate that wraps modulo 2^OUTPUT_BUF_SIZE.
  function automatic logic [OUTPUT_BUF_SIZE-1:0] mac_wrap(
      input logic [OUTPUT_BUF_SIZE-1:0] acc, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = a * b;
    return acc + OUTPUT_BUF_SIZE'(p);
  endfunction

  // Operand storage (not reset)
  logic [MEM_SIZE-1:0] ifm_map_q [2];
  logic [7:0]          ifm_dat_q [2][MEM_SIZE];
  logic [MEM_SIZE-1:0] flt_map_q [CU][2];
  logic [7:0]          flt_dat_q [CU][2][MEM_SIZE];

  // Control and accumulators
  state_t                     state_q, state_d;
  logic [RD_W-1:0]            k_q;
  logic [RD_W-1:0]            last_q;
  logic [OB_W-1:0]            acc_sel_q;
  logic                       ifm_sel_q;
  logic                       flt_sel_q;
  logic [PS-1:0]              used_q [CU];
  logic [OUTPUT_BUF_SIZE-1:0] acc_q  [CU][OUTPUT_BUF_NUM];

  // Per-unit compute view of the current sub-chunk
  logic [PS-1:0]              ifm_sub;
  logic [PS-1:0]              rem    [CU];
  logic [PS-1:0]              low    [CU];
  logic [CU-1:0]              unit_busy;
  logic                       all_last;
  int                         pos    [CU];
  logic [7:0]                 ifm_byte [CU];
  logic [7:0]                 flt_byte [CU];
  logic [OUTPUT_BUF_SIZE-1:0] rd_dat;
  logic                       start, step;

  assign start = (state_q == ST_IDLE) && cc.run_valid_i;
  assign step  = (state_q == ST_RUN)  && cc.run_valid_i;

  // Operand writes. A write only touches the addressed bank, so a compute on
  // the other bank is never disturbed.
  always_ff @(posedge clk_i) begin
    if (cc.ifm_wr_valid_i) begin
      ifm_map_q[cc.ifm_wr_sel_i][beat_base(cc.ifm_wr_count_i) +: BUS_SIZE] <= cc.ifm_sparsemap_i;
      for (int j = 0; j < BUS_SIZE; j++) begin
        ifm_dat_q[cc.ifm_wr_sel_i][beat_base(cc.ifm_wr_count_i) + AD_W'(j)] <=
          cc.ifm_nonzero_data_i[8*j +: 8];
      end
    end
    for (int u = 0; u < CU; u++) begin
      if (cc.filter_wr_valid_i && int'(cc.filter_wr_order_sel_i) == u) begin
        flt_map_q[u][cc.filter_wr_sel_i][beat_base(cc.filter_wr_count_i) +: BUS_SIZE] <=
          cc.filter_sparsemap_i;
        for (int j = 0; j < BUS_SIZE; j++) begin
          flt_dat_q[u][cc.filter_wr_sel_i][beat_base(cc.filter_wr_count_i) + AD_W'(j)] <=
            cc.filter_nonzero_data_i[8*j +: 8];
        end
      end
    end
  end

  // Match search. The lowest remaining match is isolated by rem & -rem. A unit
  // is on its last match when nothing else remains after that bit.
  always_comb begin
    ifm_sub  = sub_chunk(ifm_map_q[ifm_sel_q], k_q);
    all_last = 1'b1;
    for (int u = 0; u < CU; u++) begin
      rem[u]       = ifm_sub & sub_chunk(flt_map_q[u][flt_sel_q], k_q) & ~used_q[u];
      low[u]       = rem[u] & (~rem[u] + PS'(1));
      unit_busy[u] = |rem[u];
      pos[u]       = int'(k_q) * PS + lsb_index(low[u]);
      ifm_byte[u]  = ifm_dat_q[ifm_sel_q][rank(ifm_map_q[ifm_sel_q], pos[u])];
      flt_byte[u]  = flt_dat_q[u][flt_sel_q][rank(flt_map_q[u][flt_sel_q], pos[u])];
      if ((rem[u] & ~low[u]) != '0) all_last = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (!rst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cc.run_valid_i) state_d = ST_RUN;
      ST_RUN:  if (cc.run_valid_i && all_last && k_q == last_q) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs and accumulator readout
  always_comb begin
    rd_dat = '0;
    for (int u = 0; u < CU; u++) begin
      for (int b = 0; b < OUTPUT_BUF_NUM; b++) begin
        if (int'(cc.com_unit_out_buf_sel_i) == u && int'(cc.out_buf_sel_i) == b)
          rd_dat = acc_q[u][b];
      end
    end
  end

  assign cc.total_chunk_end_o = (state_q == ST_IDLE);
  assign cc.out_buf_dat_o     = rd_dat;

  // Run bookkeeping and accumulation. The start edge latches the run settings
  // and optionally clears the target accumulator. Each RUN step with
  // run_valid_i set consumes one match per busy unit.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      k_q       <= '0;
      last_q    <= '0;
      acc_sel_q <= '0;
      ifm_sel_q <= 1'b0;
      flt_sel_q <= 1'b0;
      for (int u = 0; u < CU; u++) begin
        used_q[u] <= '0;
        for (int b = 0; b < OUTPUT_BUF_NUM; b++) acc_q[u][b] <= '0;
      end
    end else if (start) begin
      k_q       <= '0;
      last_q    <= cc.rd_sparsemap_num_i;
      acc_sel_q <= cc.acc_buf_sel_i;
      ifm_sel_q <= cc.ifm_rd_sel_i;
      flt_sel_q <= cc.filter_rd_sel_i;
      for (int u = 0; u < CU; u++) begin
        used_q[u] <= '0;
        if (cc.chunk_start_i) acc_q[u][cc.acc_buf_sel_i] <= '0;
      end
    end else if (step) begin
      for (int u = 0; u < CU; u++) begin
        if (unit_busy[u])
          acc_q[u][acc_sel_q] <= mac_wrap(acc_q[u][acc_sel_q], ifm_byte[u], flt_byte[u]);
        if (all_last) used_q[u] <= '0;
        else          used_q[u] <= used_q[u] | low[u];
      end
      if (all_last) k_q <= (k_q == last_q) ? '0 : k_q + RD_W'(1);
    end
  end
endmodule

// File: tb/tb_compute_cluster.sv
module tb_compute_cluster;
  localparam int MEM_SIZE = 128;
  localparam int BUS_SIZE = 32;
  localparam int PS       = 32;
  localparam int CU       = 4;
  localparam int OBN      = 4;
  localparam int OBS      = 32;
  localparam int WR_CYC   = MEM_SIZE / BUS_SIZE;
  localparam int RD_NUM   = MEM_SIZE / PS;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  compute_cluster_if #(.MEM_SIZE(MEM_SIZE), .BUS_SIZE(BUS_SIZE), .PREFIX_SUM_SIZE(PS),
                       .COMPUTE_UNIT_NUM(CU), .OUTPUT_BUF_NUM(OBN), .OUTPUT_BUF_SIZE(OBS)) cc ();

  compute_cluster #(.MEM_SIZE(MEM_SIZE), .BUS_SIZE(BUS_SIZE), .PREFIX_SUM_SIZE(PS),
                    .COMPUTE_UNIT_NUM(CU), .OUTPUT_BUF_NUM(OBN), .OUTPUT_BUF_SIZE(OBS))
    dut (.clk_i(clk_i), .rst_i(rst_i), .cc(cc));

  // Reference model: what each bank holds and what each accumulator should be.
  logic [MEM_SIZE-1:0] m_ifm_map [2];
  logic [7:0]          m_ifm_dat [2][MEM_SIZE];
  logic [MEM_SIZE-1:0] m_flt_map [CU][2];
  logic [7:0]          m_flt_dat [CU][2][MEM_SIZE];
  logic [31:0]         m_acc     [CU][OBN];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Number of set map bits strictly below position p: the byte slot of p.
  function automatic int nz_rank(input logic [MEM_SIZE-1:0] map, input int p);
    int c;
    c = 0;
    for (int i = 0; i < p; i++) if (map[i]) c++;
    return c;
  endfunction

  // Run length: per sub-chunk, the busiest unit's match count, minimum one.
  function automatic int model_cycles(input int last, input int isel, input int fsel);
    int total, worst, n;
    total = 0;
    for (int k = 0; k <= last; k++) begin
      worst = 0;
      for (int u = 0; u < CU; u++) begin
        n = 0;
        for (int b = 0; b < PS; b++)
          if (m_ifm_map[isel][k*PS+b] && m_flt_map[u][fsel][k*PS+b]) n++;
        if (n > worst) worst = n;
      end
      total += (worst == 0) ? 1 : worst;
    end
    return total;
  endfunction

  task automatic model_accumulate(input int last, input int asel, input int cstart,
                                  input int isel, input int fsel);
    logic [7:0] a, b;
    for (int u = 0; u < CU; u++) begin
      if (cstart != 0) m_acc[u][asel] = 0;
      for (int p = 0; p < (last + 1) * PS; p++) begin
        if (m_ifm_map[isel][p] && m_flt_map[u][fsel][p]) begin
          a = m_ifm_dat[isel][nz_rank(m_ifm_map[isel], p)];
          b = m_flt_dat[u][fsel][nz_rank(m_flt_map[u][fsel], p)];
          m_acc[u][asel] = m_acc[u][asel] + 32'(a) * 32'(b);
        end
      end
    end
  endtask

  function automatic logic [MEM_SIZE-1:0] rand_map(input int density);
    logic [MEM_SIZE-1:0] m;
    logic [31:0] r;
    for (int w = 0; w < MEM_SIZE / 32; w++) begin
      case (density)
        0:       r = $urandom & $urandom & $urandom;
        1:       r = $urandom & $urandom;
        2:       r = $urandom;
        default: r = $urandom | $urandom;
      endcase
      m[32*w +: 32] = r;
    end
    return m;
  endfunction

  task automatic set_ifm(input int bank, input logic [MEM_SIZE-1:0] map, input int val);
    m_ifm_map[bank] = map;
    for (int i = 0; i < MEM_SIZE; i++)
      m_ifm_dat[bank][i] = (val < 0) ? 8'($urandom_range(1, 255)) : 8'(val);
  endtask

  task automatic set_flt(input int u, input int bank, input logic [MEM_SIZE-1:0] map,
                         input int val);
    m_flt_map[u][bank] = map;
    for (int i = 0; i < MEM_SIZE; i++)
      m_flt_dat[u][bank][i] = (val < 0) ? 8'($urandom_range(1, 255)) : 8'(val);
  endtask

  task automatic push_ifm(input int bank);
    for (int c = 0; c < WR_CYC; c++) begin
      cc.ifm_wr_valid_i  = 1'b1;
      cc.ifm_wr_sel_i    = 1'(bank);
      cc.ifm_wr_count_i  = 2'(c);
      cc.ifm_sparsemap_i = m_ifm_map[bank][BUS_SIZE*c +: BUS_SIZE];
      for (int j = 0; j < BUS_SIZE; j++)
        cc.ifm_nonzero_data_i[8*j +: 8] = m_ifm_dat[bank][BUS_SIZE*c + j];
      @(posedge clk_i); #1;
    end
    cc.ifm_wr_valid_i = 1'b0;
  endtask

  task automatic push_flt(input int u, input int bank);
    for (int c = 0; c < WR_CYC; c++) begin
      cc.filter_wr_valid_i     = 1'b1;
      cc.filter_wr_sel_i       = 1'(bank);
      cc.filter_wr_order_sel_i = 2'(u);
      cc.filter_wr_count_i     = 2'(c);
      cc.filter_sparsemap_i    = m_flt_map[u][bank][BUS_SIZE*c +: BUS_SIZE];
      for (int j = 0; j < BUS_SIZE; j++)
        cc.filter_nonzero_data_i[8*j +: 8] = m_flt_dat[u][bank][BUS_SIZE*c + j];
      @(posedge clk_i); #1;
    end
    cc.filter_wr_valid_i = 1'b0;
  endtask

  // One complete run, optionally with run_valid_i dropped for stall_len cycles.
  task automatic do_run(input string tag, input int last, input int asel, input int cstart,
                        input int isel, input int fsel, input int stall_at,
                        input int stall_len, output int cyc);
    int exp_cyc;
    exp_cyc = model_cycles(last, isel, fsel);
    if (stall_at < exp_cyc) exp_cyc += stall_len;
    cc.rd_sparsemap_num_i = 2'(last);
    cc.acc_buf_sel_i      = 2'(asel);
    cc.chunk_start_i      = 1'(cstart);
    cc.ifm_rd_sel_i       = 1'(isel);
    cc.filter_rd_sel_i    = 1'(fsel);
    cc.run_valid_i        = 1'b1;
    @(posedge clk_i); #1;
    check({tag, " busy"}, cc.total_chunk_end_o, 0);
    cyc = 0;
    while (cc.total_chunk_end_o === 1'b0 && cyc < 4000) begin
      cc.run_valid_i = !(cyc >= stall_at && cyc < stall_at + stall_len);
      @(posedge clk_i); #1;
      cyc++;
    end
    cc.run_valid_i   = 1'b0;
    cc.chunk_start_i = 1'b0;
    check({tag, " cycles"}, cyc, exp_cyc);
    check({tag, " end"}, cc.total_chunk_end_o, 1);
    model_accumulate(last, asel, cstart, isel, fsel);
  endtask

  task automatic read_acc(input int u, input int b, output logic [31:0] d);
    cc.com_unit_out_buf_sel_i = 2'(u);
    cc.out_buf_sel_i          = 2'(b);
    #1;
    d = cc.out_buf_dat_o;
  endtask

  task automatic check_all_acc(input string tag);
    logic [31:0] d;
    for (int u = 0; u < CU; u++) begin
      for (int b = 0; b < OBN; b++) begin
        read_acc(u, b, d);
        check($sformatf("%s acc u%0d b%0d", tag, u, b), d, m_acc[u][b]);
      end
    end
    @(posedge clk_i); #1;
  endtask

  initial begin
    logic [31:0] d;
    int cyc;
    int last, asel, cst, isel, fsel, bank;

    cc.ifm_sparsemap_i = '0; cc.ifm_nonzero_data_i = '0; cc.ifm_wr_valid_i = 1'b0;
    cc.ifm_wr_count_i = '0; cc.ifm_wr_sel_i = 1'b0; cc.ifm_rd_sel_i = 1'b0;
    cc.filter_sparsemap_i = '0; cc.filter_nonzero_data_i = '0; cc.filter_wr_valid_i = 1'b0;
    cc.filter_wr_count_i = '0; cc.filter_wr_sel_i = 1'b0; cc.filter_rd_sel_i = 1'b0;
    cc.filter_wr_order_sel_i = '0; cc.run_valid_i = 1'b0; cc.chunk_start_i = 1'b0;
    cc.rd_sparsemap_num_i = '0; cc.acc_buf_sel_i = '0; cc.out_buf_sel_i = '0;
    cc.com_unit_out_buf_sel_i = '0;
    for (int u = 0; u < CU; u++) for (int b = 0; b < OBN; b++) m_acc[u][b] = 0;

    // Reset
    rst_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset end", cc.total_chunk_end_o, 1);
    rst_i = 1'b1;
    check_all_acc("reset");

    // Dense directed data: IFM bank0 all ones / bytes 1, unit0 filter bank0 all ones / bytes 2
    set_ifm(0, '1, 1);
    set_ifm(1, '0, 0);
    for (int u = 0; u < CU; u++) begin
      set_flt(u, 0, '0, 0);
      set_flt(u, 1, '0, 0);
    end
    set_flt(0, 0, '1, 2);
    push_ifm(0); push_ifm(1);
    for (int u = 0; u < CU; u++) begin
      push_flt(u, 0); push_flt(u, 1);
    end

    do_run("dense", RD_NUM - 1, 0, 1, 0, 0, 10000, 0, cyc);
    check("dense run length", cyc, 128);
    read_acc(0, 0, d);
    check("dense acc", d, 256);
    check_all_acc("dense");

    do_run("accum", RD_NUM - 1, 0, 0, 0, 0, 10000, 0, cyc);
    read_acc(0, 0, d);
    check("accum doubled", d, 512);
    do_run("restart", RD_NUM - 1, 0, 1, 0, 0, 10000, 0, cyc);
    read_acc(0, 0, d);
    check("restart cleared", d, 256);

    do_run("stall", RD_NUM - 1, 0, 1, 0, 0, 40, 5, cyc);
    check("stall run length", cyc, 133);
    read_acc(0, 0, d);
    check("stall acc", d, 256);

    // Disjoint maps on bank1: one cycle per sub-chunk, nothing accumulated
    set_ifm(1, {4{32'h5555_5555}}, -1);
    set_flt(0, 1, {4{32'hAAAA_AAAA}}, -1);
    push_ifm(1); push_flt(0, 1);
    do_run("disjoint", RD_NUM - 1, 2, 1, 1, 1, 10000, 0, cyc);
    check("disjoint run length", cyc, RD_NUM);
    read_acc(0, 2, d);
    check("disjoint acc", d, 0);

    // Refill bank1 while bank0 computes, then compute on bank1
    set_ifm(1, rand_map(2), -1);
    for (int u = 0; u < CU; u++) set_flt(u, 1, rand_map(1 + u % 3), -1);
    fork
      do_run("shadow", RD_NUM - 1, 0, 1, 0, 0, 10000, 0, cyc);
      begin
        push_ifm(1);
        for (int u = 0; u < CU; u++) push_flt(u, 1);
      end
    join
    read_acc(0, 0, d);
    check("shadow write acc", d, 256);
    do_run("bank1", RD_NUM - 1, 1, 1, 1, 1, 10000, 0, cyc);
    check_all_acc("bank1");

    // Randomized runs
    for (int it = 0; it < 8; it++) begin
      bank = int'($urandom_range(0, 1));
      set_ifm(bank, rand_map(int'($urandom_range(0, 3))), -1);
      push_ifm(bank);
      for (int u = 0; u < CU; u++) begin
        set_flt(u, bank, rand_map(int'($urandom_range(0, 3))), -1);
        push_flt(u, bank);
      end
      last = int'($urandom_range(0, RD_NUM - 1));
      asel = int'($urandom_range(0, OBN - 1));
      cst  = int'($urandom_range(0, 1));
      isel = bank;
      fsel = int'($urandom_range(0, 1));
      do_run($sformatf("rand%0d", it), last, asel, cst, isel, fsel,
             int'($urandom_range(0, 20)), int'($urandom_range(0, 4)), cyc);
      check_all_acc($sformatf("rand%0d", it));
    end

    // Reset during a long run clears partial accumulations
    set_ifm(0, '1, 1);
    set_flt(0, 0, '1, 2);
    push_ifm(0); push_flt(0, 0);
    cc.rd_sparsemap_num_i = 2'(RD_NUM - 1);
    cc.acc_buf_sel_i = 2'd3;
    cc.chunk_start_i = 1'b0;
    cc.ifm_rd_sel_i = 1'b0;
    cc.filter_rd_sel_i = 1'b0;
    cc.run_valid_i = 1'b1;
    repeat (10) @(posedge clk_i);
    #1;
    check("midrun busy", cc.total_chunk_end_o, 0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    cc.run_valid_i = 1'b0;
    check("midrun reset end", cc.total_chunk_end_o, 1);
    for (int u = 0; u < CU; u++) for (int b = 0; b < OBN; b++) m_acc[u][b] = 0;
    check_all_acc("midrun reset");

    do_run("recover", RD_NUM - 1, 3, 0, 0, 0, 10000, 0, cyc);
    check_all_acc("recover");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/compute_cluster.md
COMPUTE_CLUSTER -- requirements
Module: compute_cluster

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- MEM_SIZE, 128, entries per IFM/filter buffer.
- BUS_SIZE, 32, entries per write beat.
- PREFIX_SUM_SIZE, 32, sparse-map bits per sub-chunk.
- COMPUTE_UNIT_NUM, 4, filters/compute units.
- OUTPUT_BUF_NUM, 4, accumulator buffers per unit.
- OUTPUT_BUF_SIZE, 32, accumulator width.
- Derived: WR_CYC = MEM_SIZE/BUS_SIZE; RD_NUM = MEM_SIZE/PREFIX_SUM_SIZE.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk_i, in, 1, single clock.
- rst_i, in, 1, synchronous active-low reset.
- ifm_sparsemap_i, in, BUS_SIZE, IFM map beat.
- ifm_nonzero_data_i, in, BUS_SIZE*8, IFM compacted bytes.
- ifm_wr_valid_i, in, 1, IFM write enable.
- ifm_wr_count_i, in, clog2(WR_CYC), beat index.
- ifm_wr_sel_i, in, 1, IFM bank written.
- ifm_rd_sel_i, in, 1, IFM bank computed.
- filter_sparsemap_i, in, BUS_SIZE, filter map beat.
- filter_nonzero_data_i, in, BUS_SIZE*8, filter bytes.
- filter_wr_valid_i, in, 1, filter write enable.
- filter_wr_count_i, in, clog2(WR_CYC), beat index.
- filter_wr_sel_i, in, 1, filter bank written.
- filter_rd_sel_i, in, 1, filter bank computed.
- filter_wr_order_sel_i, in, clog2(OUTPUT_BUF_NUM), target unit.
- run_valid_i, in, 1, run enable/stall.
- chunk_start_i, in, 1, clear accumulator at run start.
- rd_sparsemap_num_i, in, clog2(RD_NUM), last sub-chunk index.
- total_chunk_end_o, out, 1, idle/done.
- acc_buf_sel_i, in, clog2(OUTPUT_BUF_NUM), accumulator target.
- out_buf_sel_i, in, clog2(OUTPUT_BUF_NUM), readout buffer.
- com_unit_out_buf_sel_i, in, clog2(COMPUTE_UNIT_NUM), readout unit.
- out_buf_dat_o, out, OUTPUT_BUF_SIZE, readout data.

Function
REQ-003 IFM storage: 2 banks, each MEM_SIZE map bits + MEM_SIZE bytes. Edge with ifm_wr_valid_i=1 writes map[BUS_SIZE*cnt +: BUS_SIZE] and bytes[BUS_SIZE*cnt +: BUS_SIZE] of bank ifm_wr_sel_i.
REQ-004 Filter storage: 2 banks per unit, same layout; writes go to unit filter_wr_order_sel_i (out-of-range value: no write), bank filter_wr_sel_i.
REQ-005 Byte arrays hold nonzero values compacted in map order; data of set map bit p = byte[popcount(map[p-1:0])].
REQ-006 Writing a bank never disturbs the bank selected for read; same-bank write during compute is allowed, and unwritten entries are read as stored.
REQ-007 FSM IDLE/RUN. In IDLE, total_chunk_end_o=1; in RUN, 0.
REQ-008 IDLE->RUN on edge with run_valid_i=1. Latch rd_sparsemap_num_i, acc_buf_sel_i, chunk_start_i, ifm_rd_sel_i, filter_rd_sel_i. Sub-chunk k=0.
REQ-009 If latched chunk_start=1, each unit's accumulator[acc_sel] is zeroed at the start edge; otherwise it keeps its value.
REQ-010 RUN, run_valid_i=1: each unit computes match = ifm_map & filter_map over sub-chunk k (PREFIX_SUM_SIZE bits). Each cycle it consumes the lowest unconsumed match and adds the unsigned 8x8 product of its two bytes to accumulator[acc_sel], modulo 2^OUTPUT_BUF_SIZE.
REQ-011 Unit with no remaining matches idles. Sub-chunk with zero matches costs 1 cycle.
REQ-012 When all units have exhausted sub-chunk k, k increments next cycle. When k = latched last index is exhausted, FSM returns to IDLE next edge.
REQ-013 run_valid_i=0 in RUN freezes all state, with no accumulation.
REQ-014 out_buf_dat_o = accumulator[com_unit_out_buf_sel_i][out_buf_sel_i], combinational; it reflects accumulations from prior edges.

Reset
REQ-015 rst_i=0 at clock edge: FSM=IDLE, k=0, all accumulators=0, total_chunk_end_o=1, out_buf_dat_o=0. Memory contents are not reset.
REQ-016 Reset mid-RUN aborts the run; partial accumulations are cleared.

Verification
REQ-017 After reset: total_chunk_end_o=1, out_buf_dat_o=0 for all selects.
REQ-018 IFM bank0 all ones map, bytes=1; unit0 filter bank0 all ones, bytes=2; rd_sparsemap_num=RD_NUM-1; chunk_start=1, run_valid=1 -> RUN 128 cycles, then acc0 of unit0 = 256, end=1.
REQ-019 Disjoint IFM/filter maps -> RD_NUM cycles in RUN, acc=0.
REQ-020 Second run with chunk_start=0, same data -> acc doubles (512); with chunk_start=1 -> 256.
REQ-021 run_valid dropped 5 cycles mid-run -> completion delayed exactly 5 cycles, same result.
REQ-022 Write bank1 while computing bank0 -> result unchanged; swap rd_sel -> bank1 result in acc_buf_sel=1.
